// File: rtl/fft_stream_host_pkg.sv
// fft_stream_host_pkg: shared state encoding and helpers for the FFT stream host
package fft_stream_host_pkg;
  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LOAD,
    ST_PAD,
    ST_START,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_READ,
    ST_DRAIN
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_out_fifo.sv
// fft_out_fifo: small synchronous FIFO with occupancy count, head visible on data_o
module fft_out_fifo
  import fft_stream_host_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);
  localparam int PW = DEPTH > 1 ? clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic full, do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign data_o = mem_q[rp_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= data_i;
        wp_q <= wp_q == PTR_LAST ? '0 : wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q == PTR_LAST ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // the upstream credit check must make a push into a full FIFO impossible
  assert property (@(posedge clk) disable iff (rst) !(push_i && full && !pop_i));
endmodule

// File: rtl/fft_stream_host.sv
// fft_stream_host: loads a zero-padded frame into fft_pipeline, starts it, streams the spectrum out
module fft_stream_host
  import fft_stream_host_pkg::*;
#(
  parameter int N = 1024,
  parameter int IN_W = 10,
  parameter int OUT_W = 21,
  parameter int AW = 10,
  parameter int RD_LAT = 2,
  parameter int BIT_REV = 1,
  parameter int TIMEOUT = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             fft_load,
  output logic [AW-1:0]    fft_addr_wr,
  output logic [IN_W-1:0]  fft_in_data,
  output logic             fft_start,
  input  logic             fft_done,
  output logic [AW-1:0]    fft_addr_rd,
  input  logic [OUT_W-1:0] fft_real,
  input  logic [OUT_W-1:0] fft_img,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_real,
  output logic [OUT_W-1:0] m_img,
  output logic [AW-1:0]    m_index,
  output logic             m_last,
  output logic             busy,
  output logic             err_timeout
);
  localparam int FIFO_D = RD_LAT + 2;
  localparam int TW = clog2(TIMEOUT + 1);
  localparam int CW = clog2(FIFO_D + 1);
  localparam int LW = clog2(RD_LAT + 1);
  localparam int FW = 2 * OUT_W + AW + 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d;
  logic [RD_LAT-1:0] vld_q, lst_q;
  logic [AW-1:0] idx_q [RD_LAT];
  logic [LW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic fifo_empty, credit, issue, s_hs, waiting, tmo_hit, timeout;
  logic [FW-1:0] fifo_dout;

  assign s_hs = s_valid && s_ready;
  assign waiting = state_q == ST_WAIT_LO || state_q == ST_WAIT_HI;
  assign tmo_hit = tmo_q == TW'(TIMEOUT);
  // a completion seen in the same cycle as the limit still counts as a normal finish
  assign timeout = waiting && tmo_hit && !(state_q == ST_WAIT_HI && fft_done);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + LW'(vld_q[i]);
  end

  // reads already in the shift line hold a FIFO slot, so the FIFO can never overflow
  assign credit = int'(fifo_cnt) + int'(inflight) < FIFO_D;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_SYNC;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:    if (fft_done) state_d = ST_LOAD;
      ST_LOAD:    if (s_hs && wcnt_q == LAST) state_d = ST_START;
                  else if (s_hs && s_last) state_d = ST_PAD;
      ST_PAD:     if (wcnt_q == LAST) state_d = ST_START;
      ST_START:   state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (tmo_hit) state_d = ST_READ;
                  else if (!fft_done) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (fft_done || tmo_hit) state_d = ST_READ;
      ST_READ:    if (issue && rcnt_q == LAST) state_d = ST_DRAIN;
      ST_DRAIN:   if (inflight == '0 && fifo_empty) state_d = ST_LOAD;
      default:    state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    s_ready = state_q == ST_LOAD;
    fft_load = (s_valid && state_q == ST_LOAD) || state_q == ST_PAD;
    fft_addr_wr = fft_load ? wcnt_q : '0;
    fft_in_data = (s_valid && state_q == ST_LOAD) ? s_data : '0;
    fft_start = state_q == ST_START;
    busy = state_q != ST_LOAD;
    issue = state_q == ST_READ && credit;
  end

  always_comb begin
    wcnt_d = state_q == ST_DRAIN ? '0 : fft_load ? wcnt_q + 1'b1 : wcnt_q;
    rcnt_d = issue ? rcnt_q + 1'b1 : rcnt_q;
    tmo_d = state_q == ST_START ? '0 : (waiting && !tmo_hit) ? tmo_q + 1'b1 : tmo_q;
    err_d = err_q || timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      vld_q <= '0;
      lst_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      vld_q[0] <= issue;
      lst_q[0] <= rcnt_q == LAST;
      idx_q[0] <= rcnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign fft_addr_rd = BIT_REV != 0 ? AW'(bitrev(32'(rcnt_q), AW)) : rcnt_q;
  assign err_timeout = err_q;

  fft_out_fifo #(.DEPTH(FIFO_D), .W(FW), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_q[RD_LAT-1]),
    .data_i  ({idx_q[RD_LAT-1], lst_q[RD_LAT-1], fft_real, fft_img}),
    .pop_i   (m_ready),
    .data_o  (fifo_dout),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign {m_index, m_last, m_real, m_img} = fifo_empty ? '0 : fifo_dout;
endmodule

// File: tb/tb_fft_stream_host.sv
// tb_fft_stream_host: two hosts (bit-reversed and natural order) in lockstep against a behavioural FFT
module tb_fft_stream_host;
  localparam int N = 1024;
  localparam int IN_W = 10;
  localparam int OUT_W = 21;
  localparam int AW = 10;
  localparam int TIMEOUT = 8192;

  logic clk = 1'b0;
  logic rst, s_valid, s_last, m_ready, hold;
  logic [IN_W-1:0] s_data;
  int n_vec = 0, n_err = 0, cyc = 0, fin = 0, duty = 100;
  logic [IN_W-1:0] fr [4][N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic give_up(input string tag);
    check(tag, 64'd0, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  function automatic int brev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic s_ready, fft_load, fft_start, fft_done, m_valid, m_last, busy, err_timeout;
    logic [AW-1:0] fft_addr_wr, fft_addr_rd, m_index;
    logic [IN_W-1:0] fft_in_data;
    logic [OUT_W-1:0] fft_real, fft_img, m_real, m_img, ev, ei;
    logic [IN_W-1:0] ram [N];
    logic [IN_W+AW-1:0] p1, p2;
    logic [2*OUT_W+AW+1:0] cur, held;
    logic stall = 1'b0;
    int dcnt = 0, fo = 0, wf = 0, k_out = 0, wexp = 0, nstart = 0, t_start = 0, a;

    fft_stream_host #(
      .N(N), .IN_W(IN_W), .OUT_W(OUT_W), .AW(AW), .RD_LAT(2),
      .BIT_REV(g == 0 ? 1 : 0), .TIMEOUT(TIMEOUT)
    ) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .fft_load(fft_load), .fft_addr_wr(fft_addr_wr),
      .fft_in_data(fft_in_data), .fft_start(fft_start), .fft_done(fft_done),
      .fft_addr_rd(fft_addr_rd), .fft_real(fft_real), .fft_img(fft_img),
      .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_img(m_img),
      .m_index(m_index), .m_last(m_last), .busy(busy), .err_timeout(err_timeout)
    );

    // behavioural FFT: RAM, two-cycle read latency, busy for 50 cycles per start
    assign fft_done = dcnt == 0 && !hold;
    assign fft_real = {1'b0, p2};
    assign fft_img = ~{1'b0, p2};
    always @(posedge clk) begin
      if (fft_load) ram[fft_addr_wr] <= fft_in_data;
      p1 <= {ram[fft_addr_rd], fft_addr_rd};
      p2 <= p1;
      dcnt <= fft_start ? 50 : (dcnt > 0 ? dcnt - 1 : 0);
    end

    always @(negedge clk) begin
      cur = {m_valid, m_index, m_last, m_real, m_img};
      if (rst) begin
        k_out = 0;
        wexp = 0;
        nstart = 0;
        stall = 1'b0;
      end else begin
        if (stall) check("stable", cur, held);
        if (fft_load) begin
          check("wr_addr", fft_addr_wr, wexp);
          check("wr_data", fft_in_data, fr[wf % 4][fft_addr_wr]);
          check("load_start_excl", fft_start, 0);
          if (s_ready) check("busy_load", busy, 0);
          if (wexp == N - 1) begin
            wexp = 0;
            wf++;
          end else wexp++;
        end
        if (fft_start) begin
          nstart++;
          t_start = cyc;
          check("busy_start", busy, 1);
        end
        if (m_valid && m_ready) begin
          a = g == 0 ? brev(k_out) : k_out;
          ev = {1'b0, fr[fo % 4][a], AW'(a)};
          ei = ~ev;
          check("m_index", m_index, k_out);
          check("m_last", m_last, k_out == N - 1);
          check("m_real", m_real, ev);
          check("m_img", m_img, ei);
          if (k_out == N - 1) begin
            check("one_start", nstart, 1);
            nstart = 0;
            k_out = 0;
            fo++;
          end else k_out++;
        end
        stall = m_valid && !m_ready;
        held = cur;
      end
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = $urandom_range(99) < duty;
    end
  end

  task automatic send_frame(input int len, input int gap, input bit seq);
    int s, t;
    logic acc;
    s = fin % 4;
    for (int i = 0; i < N; i++) fr[s][i] = '0;
    for (int i = 0; i < len; i++) begin
      fr[s][i] = seq ? IN_W'(i) : IN_W'($urandom);
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data = fr[s][i];
      s_last = i == len - 1;
      t = 0;
      forever begin
        acc = g_dut[0].s_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        if (++t > 20000) give_up("s_ready_wait");
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    fin++;
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (g_dut[0].fo < target || g_dut[1].fo < target) begin
      @(posedge clk);
      #1;
      if (++t > 40000) give_up("out_wait");
    end
  endtask

  task automatic idle_check();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_extra0", g_dut[0].m_valid, 0);
    check("no_extra1", g_dut[1].m_valid, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", g_dut[0].s_ready, 0);
    check("rst_load", g_dut[0].fft_load, 0);
    check("rst_start", g_dut[0].fft_start, 0);
    check("rst_m_valid", g_dut[0].m_valid, 0);
    check("rst_m_index", g_dut[0].m_index, 0);
    check("rst_addr_rd", g_dut[0].fft_addr_rd, 0);
    check("rst_err", g_dut[0].err_timeout, 0);
    check("rst_m_valid1", g_dut[1].m_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send_frame(N, 0, 1'b1);
    wait_out(1);
    idle_check();
    check("err_clean", g_dut[0].err_timeout, 0);

    send_frame(100, 20, 1'b0);
    wait_out(2);
    idle_check();

    duty = 30;
    send_frame(N, 10, 1'b0);
    wait_out(3);
    duty = 100;
    idle_check();

    hold = 1'b1;
    send_frame(300, 0, 1'b0);
    t = 0;
    while (!g_dut[0].err_timeout) begin
      @(posedge clk);
      #1;
      if (++t > 12000) give_up("tmo_wait");
    end
    check("tmo_delay", (cyc - g_dut[0].t_start) inside {[TIMEOUT:TIMEOUT+8]}, 1);
    check("tmo_err1", g_dut[1].err_timeout, 1);
    hold = 1'b0;
    wait_out(4);
    check("tmo_sticky", g_dut[0].err_timeout, 1);

    send_frame(N, 0, 1'b0);
    t = 0;
    while (g_dut[0].nstart == 0) begin
      @(posedge clk);
      #1;
      if (++t > 5000) give_up("start_wait");
    end
    repeat (10) @(posedge clk);
    #1;
    hold = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("sync_s_ready0", g_dut[0].s_ready, 0);
      check("sync_s_ready1", g_dut[1].s_ready, 0);
      check("sync_m_valid", g_dut[0].m_valid, 0);
    end
    check("err_rst", g_dut[0].err_timeout, 0);
    g_dut[0].fo = fin;
    g_dut[1].fo = fin;
    hold = 1'b0;
    t = 0;
    while (!g_dut[0].s_ready) begin
      @(posedge clk);
      #1;
      if (++t > 100) give_up("sync_wait");
    end
    check("sync_done", g_dut[0].fft_done, 1);

    send_frame(N, 0, 1'b0);
    send_frame(1, 0, 1'b0);
    wait_out(7);
    idle_check();
    check("err_final", g_dut[1].err_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
